// File: rtl/chipper_pkg.sv
// ---------------------------------------------------------------------------
// chipper_pkg
// Shared definitions for the CHIPPER local port logic: flit width, flit field
// positions, link indices and the flit type.
// ---------------------------------------------------------------------------
package chipper_pkg;

   localparam int FLIT_W = 10;

   // Flit field positions: [9]=valid, [8:6]=tag, [5:0]=destination id
   localparam int VALID_BIT = 9;
   localparam int TAG_MSB   = 8;
   localparam int TAG_LSB   = 6;
   localparam int DST_MSB   = 5;
   localparam int DST_LSB   = 0;

   // Link indices. They also give the fixed N,E,S,W scan order.
   localparam logic [1:0] P_N = 2'd0;
   localparam logic [1:0] P_E = 2'd1;
   localparam logic [1:0] P_S = 2'd2;
   localparam logic [1:0] P_W = 2'd3;

   typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/chipper_inj_fifo.sv
// ---------------------------------------------------------------------------
// chipper_inj_fifo
// Small synchronous FIFO that holds locally generated flits until they can be
// injected into a free link slot.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset (empties the queue)
//   push   - write din at the tail (ignored when full)
//   pop    - drop the head entry (ignored when empty)
//   din    - flit to enqueue
//   dout   - current head flit (valid only when !empty)
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module chipper_inj_fifo
   import chipper_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  flit_t                  din,
   output flit_t                  dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   flit_t            mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array has no reset; only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   // A simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/chipper_local_port_ctrl.sv
// ---------------------------------------------------------------------------
// chipper_local_port_ctrl
// Local injection/ejection stage in front of the CHIPPER deflection router.
// Each cycle it ejects at most one flit addressed to this node (round-robin
// over N,E,S,W), injects the local queue head into the first empty slot, and
// registers the four slots towards the router core.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   nin/ein/sin/win     - flits arriving on the N/E/S/W links
//   lin                 - local flit to inject (pushed when lin[9] && lin_ready)
//   lin_ready           - queue not full (combinational)
//   n2r/e2r/s2r/w2r     - registered slot flits to the router core
//   lout                - registered ejected flit (lout[9]=1 when valid)
//   starve              - registered; queue head blocked for STARVE_LIM cycles
//   fifo_count          - registered queue occupancy
// ---------------------------------------------------------------------------
module chipper_local_port_ctrl
   import chipper_pkg::*;
#(
   parameter logic [5:0] NODE_ID    = 6'd45,
   parameter int         FIFO_DEPTH = 4,
   parameter int         STARVE_LIM = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  flit_t                       nin,
   input  flit_t                       ein,
   input  flit_t                       sin,
   input  flit_t                       win,
   input  flit_t                       lin,
   output logic                        lin_ready,
   output flit_t                       n2r,
   output flit_t                       e2r,
   output flit_t                       s2r,
   output flit_t                       w2r,
   output flit_t                       lout,
   output logic                        starve,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int SW = $clog2(STARVE_LIM+1);

   flit_t          link_in [4];
   flit_t          slots   [4];
   logic [1:0]     rr_ptr;
   logic [1:0]     scan_idx;
   logic           ej_found;
   logic [1:0]     ej_idx;
   logic           inj_found;
   logic [1:0]     inj_idx;
   logic           inj_do;
   logic [SW-1:0]  starve_cnt;
   logic [SW-1:0]  starve_next;
   logic           fifo_full;
   logic           fifo_empty;
   flit_t          fifo_head;
   logic           push;

   assign lin_ready = !fifo_full;
   assign push      = lin[VALID_BIT] && lin_ready;

   chipper_inj_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (inj_do),
      .din   (lin),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Ejection: first local-destined valid flit scanning from the RR pointer.
   always_comb begin
      link_in[P_N] = nin;
      link_in[P_E] = ein;
      link_in[P_S] = sin;
      link_in[P_W] = win;
      ej_found = 1'b0;
      ej_idx   = rr_ptr;
      scan_idx = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr + 2'(k);
         if (!ej_found && link_in[scan_idx][VALID_BIT] &&
             (link_in[scan_idx][DST_MSB:DST_LSB] == NODE_ID)) begin
            ej_found = 1'b1;
            ej_idx   = scan_idx;
         end
      end
   end

   // Injection runs after ejection, so a slot just emptied by ejection is
   // eligible. The scan for an empty slot is fixed N,E,S,W priority.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         slots[k] = link_in[k];
      end
      if (ej_found) begin
         slots[ej_idx] = '0;
      end
      inj_found = 1'b0;
      inj_idx   = P_N;
      for (int k = 0; k < 4; k++) begin
         if (!inj_found && !slots[k][VALID_BIT]) begin
            inj_found = 1'b1;
            inj_idx   = 2'(k);
         end
      end
      inj_do = inj_found && !fifo_empty;
      if (inj_do) begin
         slots[inj_idx] = fifo_head;
      end
   end

   // Starvation counter: counts blocked cycles of a non-empty queue and
   // saturates at the limit so the flag stays up until an inject happens.
   always_comb begin
      if (fifo_empty || inj_do) begin
         starve_next = '0;
      end else if (starve_cnt < SW'(STARVE_LIM)) begin
         starve_next = starve_cnt + 1'b1;
      end else begin
         starve_next = starve_cnt;
      end
   end

   // Output registers, RR pointer and starvation state. The flag is derived
   // from the next counter value so it tracks the counter in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         n2r        <= '0;
         e2r        <= '0;
         s2r        <= '0;
         w2r        <= '0;
         lout       <= '0;
         rr_ptr     <= P_N;
         starve_cnt <= '0;
         starve     <= 1'b0;
      end else begin
         n2r        <= slots[P_N];
         e2r        <= slots[P_E];
         s2r        <= slots[P_S];
         w2r        <= slots[P_W];
         lout       <= ej_found ? link_in[ej_idx] : '0;
         if (ej_found) begin
            rr_ptr <= ej_idx + 2'd1;
         end
         starve_cnt <= starve_next;
         starve     <= (starve_next == SW'(STARVE_LIM));
      end
   end

endmodule

// File: tb/tb_chipper_local_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chipper_local_port_ctrl
// Drives directed scenarios followed by random traffic. A queue-based model
// of the port predicts each cycle's outputs; a monitor compares them.
// ---------------------------------------------------------------------------
module tb_chipper_local_port_ctrl;
   import chipper_pkg::*;

   localparam logic [5:0] NODE = 6'd45;
   localparam int         DEPTH = 4;
   localparam int         LIM = 8;

   logic       clk = 1'b0;
   logic       rst;
   flit_t      nin, ein, sin, win, lin;
   logic       linReady;
   flit_t      n2r, e2r, s2r, w2r, lout;
   logic       starve;
   logic [2:0] fifoCount;

   always #5 clk = ~clk;

   chipper_local_port_ctrl #(
      .NODE_ID    (NODE),
      .FIFO_DEPTH (DEPTH),
      .STARVE_LIM (LIM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .nin        (nin),
      .ein        (ein),
      .sin        (sin),
      .win        (win),
      .lin        (lin),
      .lin_ready  (linReady),
      .n2r        (n2r),
      .e2r        (e2r),
      .s2r        (s2r),
      .w2r        (w2r),
      .lout       (lout),
      .starve     (starve),
      .fifo_count (fifoCount)
   );

   typedef struct {
      flit_t      slot [4];
      flit_t      ej;
      logic       st;
      logic [2:0] cnt;
   } exp_t;

   exp_t  expQ [$];
   flit_t modelQ [$];
   int    modelRr = 0;
   int    modelStarve = 0;
   bit    modelReady = 0;
   int    errors = 0;
   int    checks = 0;

   localparam flit_t LOC = 10'b1000101101;
   localparam flit_t NL  = 10'b1001000001;
   localparam flit_t F1  = 10'b1000000101;
   localparam flit_t Z   = 10'b0;

   // One comparison: counts it and reports a failure line when it differs.
   task automatic checkField(input string name, input logic [9:0] act, input logic [9:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model of one clock edge: eject round-robin, then inject the
   // queue head into the first empty slot, then accept the local push.
   task automatic modelStep(input logic r, input flit_t n, input flit_t e, input flit_t s,
                            input flit_t w, input flit_t l);
      exp_t  x;
      flit_t links [4];
      int    winner = -1;
      int    startSize;
      bit    injected = 0;
      links = '{n, e, s, w};
      x.ej = '0;
      if (r) begin
         x.slot = '{Z, Z, Z, Z};
         modelQ.delete();
         modelRr = 0;
         modelStarve = 0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (modelRr + k) % 4;
            if (winner < 0 && links[idx][9] && links[idx][5:0] == NODE) winner = idx;
         end
         x.slot = links;
         if (winner >= 0) begin
            x.ej = links[winner];
            x.slot[winner] = '0;
            modelRr = (winner + 1) % 4;
         end
         startSize = modelQ.size();
         if (startSize > 0) begin
            for (int k = 0; k < 4; k++) begin
               if (!injected && !x.slot[k][9]) begin
                  x.slot[k] = modelQ.pop_front();
                  injected = 1;
               end
            end
         end
         if (l[9] && startSize < DEPTH) modelQ.push_back(l);
         if (startSize == 0 || injected) modelStarve = 0;
         else if (modelStarve < LIM) modelStarve++;
      end
      x.st  = (modelStarve == LIM);
      x.cnt = 3'(modelQ.size());
      expQ.push_back(x);
   endtask

   // Drive one cycle of inputs away from the rising edge and log the prediction.
   task automatic applyStimulus(input logic r, input flit_t n, input flit_t e, input flit_t s,
                                input flit_t w, input flit_t l);
      @(negedge clk);
      rst = r; nin = n; ein = e; sin = s; win = w; lin = l;
      #1;
      if (modelReady) checkField("lin_ready_pre", {9'b0, linReady}, {9'b0, (modelQ.size() < DEPTH)});
      modelStep(r, n, e, s, w, l);
      if (r) modelReady = 1;
   endtask

   // Compares the registered outputs against one popped prediction.
   task automatic checkOutput(input exp_t x);
      checkField("n2r", n2r, x.slot[0]);
      checkField("e2r", e2r, x.slot[1]);
      checkField("s2r", s2r, x.slot[2]);
      checkField("w2r", w2r, x.slot[3]);
      checkField("lout", lout, x.ej);
      checkField("starve", {9'b0, starve}, {9'b0, x.st});
      checkField("fifo_count", {7'b0, fifoCount}, {7'b0, x.cnt});
      checkField("lin_ready", {9'b0, linReady}, {9'b0, (x.cnt != 3'(DEPTH))});
   endtask

   // Monitor: after each rising edge, consume the prediction made for it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) checkOutput(expQ.pop_front());
      end
   end

   function automatic flit_t randLink();
      case ($urandom_range(0, 3))
         0:       return {1'b0, 9'($urandom)};
         1:       return {1'b1, 3'($urandom), NODE};
         default: return {1'b1, 3'($urandom), 6'($urandom)};
      endcase
   endfunction

   initial begin
      flit_t pend;
      rst = 1'b1; nin = '0; ein = '0; sin = '0; win = '0; lin = '0;

      // Reset and round-robin ejection of two local flits on N and E.
      applyStimulus(1, Z, Z, Z, Z, Z);
      applyStimulus(1, Z, Z, Z, Z, Z);
      applyStimulus(0, LOC, LOC, Z, Z, Z);
      applyStimulus(0, LOC, LOC, Z, Z, Z);

      // Push F1 with links busy, then offer a free south slot.
      applyStimulus(0, NL, NL, NL, NL, F1);
      applyStimulus(0, NL, NL, Z, NL, Z);

      // Eject on W frees that slot for the queue head in the same cycle.
      applyStimulus(0, NL, NL, NL, NL, 10'b1010000111);
      applyStimulus(0, NL, NL, NL, LOC, Z);

      // Fill the queue while blocked, hold a fifth flit, then drain slowly.
      for (int i = 0; i < 4; i++) applyStimulus(0, NL, NL, NL, NL, {1'b1, 3'(i), 6'(i + 8)});
      for (int i = 0; i < 3; i++) applyStimulus(0, NL, NL, NL, NL, 10'b1111111111);
      applyStimulus(0, NL, NL, Z, NL, 10'b1111111111);
      applyStimulus(0, NL, NL, Z, NL, Z);
      // Push and pop together at count 2.
      applyStimulus(0, NL, Z, NL, NL, 10'b1101010101);

      // Starvation: keep the queue blocked past the limit, then release.
      for (int i = 0; i < LIM + 2; i++) applyStimulus(0, NL, NL, NL, NL, Z);
      applyStimulus(0, NL, NL, Z, NL, Z);
      applyStimulus(0, NL, NL, NL, NL, Z);

      // Reset mid-traffic with three queued flits.
      applyStimulus(1, Z, Z, Z, Z, Z);
      for (int i = 0; i < 3; i++) applyStimulus(0, NL, NL, NL, NL, {1'b1, 3'(i), 6'(i)});
      applyStimulus(1, LOC, NL, LOC, Z, F1);
      applyStimulus(0, Z, Z, Z, Z, Z);

      // Random traffic; the source holds an unaccepted flit.
      pend = '0;
      for (int i = 0; i < 600; i++) begin
         logic  r;
         bit    accepted;
         flit_t l;
         r = ($urandom_range(0, 99) == 0);
         if (!pend[9] && $urandom_range(0, 1) == 1) pend = {1'b1, 3'($urandom), 6'($urandom)};
         l = pend[9] ? pend : {1'b0, 9'($urandom)};
         accepted = pend[9] && (modelQ.size() < DEPTH) && !r;
         applyStimulus(r, randLink(), randLink(), randLink(), randLink(), l);
         if (accepted || r) pend = '0;
      end
      applyStimulus(0, Z, Z, Z, Z, Z);

      // Let the monitor consume outstanding predictions, with a bound.
      for (int i = 0; i < 10; i++) begin
         if (expQ.size() == 0) break;
         @(posedge clk);
         #2;
      end
      checkField("drain", 10'(expQ.size()), 10'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
